div_meter: RTL and testbench
============================

DIV_METER -- requirements
Module: div_meter

Interface
REQ-001 SHALL have parameter WIDTH, 8, bit width of the period/high-time counters and of both result outputs; legal range 2..16.
REQ-002 SHALL have port clk_sig  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_sig  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_sig  input  1  slow periodic signal to measure, e.g. the divided output of the team's clock divider.
REQ-005 SHALL have port start_sig  input  1  one-cycle request to perform one measurement.
REQ-006 SHALL have port busy_sig  output  1  high while a measurement is in progress.
REQ-007 SHALL have port valid_sig  output  1  one-cycle pulse marking new results.
REQ-008 SHALL have port err_sig  output  1  one-cycle pulse marking a timeout.
REQ-009 SHALL have port period_sig  output  WIDTH  measured period in clk_sig cycles.
REQ-010 SHALL have port high_sig  output  WIDTH  measured high time in clk_sig cycles.

Function
REQ-011 SHALL register in_sig through a sampling stage, giving s; previous value p; rise = s & ~p.
REQ-012 SHALL implement states IDLE, WAIT_RISE, MEASURE; busy_sig = 1 in WAIT_RISE and MEASURE.
REQ-013 IDLE: start_sig = 1 -> WAIT_RISE and clear the wait counter; start_sig in any other state SHALL be ignored.
REQ-014 WAIT_RISE: on rise -> MEASURE, with period counter = 1 and high counter = 1; otherwise increment the wait counter.
REQ-015 MEASURE: each cycle without rise: period counter + 1, high counter + s.
REQ-016 MEASURE on rise: load period_sig = period counter and high_sig = high counter, pulse valid_sig the next cycle, -> IDLE.
REQ-017 Timeout: when the wait counter or period counter reaches 2^WIDTH-1 without rise, pulse err_sig, -> IDLE, period_sig and high_sig unchanged.
REQ-018 A rise and a counter reaching 2^WIDTH-1 in the same cycle SHALL be treated as a rise, not a timeout.
REQ-019 valid_sig and err_sig SHALL be registered, never both high, each high exactly one cycle per event.
REQ-020 period_sig and high_sig SHALL hold their value until the next valid_sig.
REQ-021 Counters SHALL NOT wrap; high counter <= period counter always.
REQ-022 A start_sig asserted in the same cycle that valid_sig or err_sig is high SHALL be accepted, since the FSM is already in IDLE.

Reset
REQ-023 rst_sig high SHALL immediately force IDLE and clear all counters, sampling registers, busy_sig, valid_sig, err_sig, period_sig and high_sig to 0, including mid-measurement.
REQ-024 After rst_sig is released, no valid_sig or err_sig SHALL occur until a new start_sig is given.

Configuration
REQ-025 Macro DIV_METER_SYNC_EN defined: the sampling stage SHALL be a 2-flop synchronizer, giving in_sig-to-s latency of 2 cycles.
REQ-026 Macro DIV_METER_SYNC_EN undefined: the sampling stage SHALL be a single flop with latency 1 cycle; measured values are identical in both builds.

Verification
REQ-027 in_sig = divider output NUM=4 DUTY=2, start_sig pulse -> valid_sig pulse, period_sig=4, high_sig=2, err_sig never high.
REQ-028 NUM=5 DUTY=1, then NUM=5 DUTY=4, each with its own start_sig -> period_sig=5/high_sig=1, then period_sig=5/high_sig=4.
REQ-029 WIDTH=8, in_sig held 0, start_sig -> err_sig pulses 255 cycles after entering WAIT_RISE; period_sig and high_sig keep their prior values.
REQ-030 start_sig re-pulsed while busy_sig=1 -> exactly one valid_sig for that measurement; start_sig in the valid_sig cycle -> second measurement begins.
REQ-031 rst_sig asserted mid-MEASURE (asynchronously, between clock edges) -> all outputs 0 at once, no valid_sig after release, next start_sig measures correctly.
REQ-032 Run REQ-027 in both DIV_METER_SYNC_EN builds -> identical results; valid_sig 1 cycle later in the synchronized build.

Source files
------------

// File: rtl/div_meter.sv
// -----------------------------------------------------------------------------
// div_meter
// Measures the period and high time of a slow periodic input (typically the
// output of a clock divider), counted in clk_sig cycles, one measurement per
// start_sig request.
//
// Ports
//   clk_sig     in   system clock, rising edge
//   rst_sig     in   asynchronous active-high reset
//   in_sig      in   signal to measure
//   start_sig   in   one-cycle measurement request (ignored while busy)
//   busy_sig    out  high while waiting for the first rise or measuring
//   valid_sig   out  one-cycle pulse: period_sig/high_sig just updated
//   err_sig     out  one-cycle pulse: no rise seen before a counter ran out
//   period_sig  out  last measured period   [WIDTH-1:0]
//   high_sig    out  last measured high time [WIDTH-1:0]
//
// Build option
//   DIV_METER_SYNC_EN  defined: in_sig passes a 2-flop synchronizer (2-cycle
//                      latency); undefined: single sampling flop (1 cycle).
//                      Measured values are the same in both builds.
// -----------------------------------------------------------------------------
module div_meter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_sig,
    input  logic             rst_sig,
    input  logic             in_sig,
    input  logic             start_sig,
    output logic             busy_sig,
    output logic             valid_sig,
    output logic             err_sig,
    output logic [WIDTH-1:0] period_sig,
    output logic [WIDTH-1:0] high_sig
);

    // A counter "reaches" the all-ones limit in the cycle it would step onto
    // it, so the timeout test compares against limit-1.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s_q, s_d;
    logic             p_q, p_d;
    logic [WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             rise;

`ifdef DIV_METER_SYNC_EN
    logic             sync1_q, sync1_d;
`endif

    assign rise = s_q & ~p_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        per_cnt_d  = per_cnt_q;
        high_cnt_d = high_cnt_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        p_d        = s_q;
`ifdef DIV_METER_SYNC_EN
        sync1_d    = in_sig;
        s_d        = sync1_q;
`else
        s_d        = in_sig;
`endif

        case (state_q)
            IDLE: begin
                if (start_sig) begin
                    state_d    = WAIT_RISE;
                    wait_cnt_d = '0;
                end
            end
            WAIT_RISE: begin
                // The rise cycle itself is cycle 1 of the period, and s is high in it.
                if (rise) begin
                    state_d    = MEASURE;
                    per_cnt_d  = ONE;
                    high_cnt_d = ONE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + ONE;
                end
            end
            MEASURE: begin
                // A rise wins over the limit being reached in the same cycle.
                if (rise) begin
                    state_d  = IDLE;
                    period_d = per_cnt_q;
                    high_d   = high_cnt_q;
                    valid_d  = 1'b1;
                end else if (per_cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    per_cnt_d  = per_cnt_q + ONE;
                    high_cnt_d = high_cnt_q + {{(WIDTH-1){1'b0}}, s_q};
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_sig or posedge rst_sig) begin
        if (rst_sig) begin
            state_q    <= IDLE;
            s_q        <= 1'b0;
            p_q        <= 1'b0;
            wait_cnt_q <= '0;
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef DIV_METER_SYNC_EN
            sync1_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            p_q        <= p_d;
            wait_cnt_q <= wait_cnt_d;
            per_cnt_q  <= per_cnt_d;
            high_cnt_q <= high_cnt_d;
            period_q   <= period_d;
            high_q     <= high_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
`ifdef DIV_METER_SYNC_EN
            sync1_q    <= sync1_d;
`endif
        end
    end

    assign busy_sig   = busy_q;
    assign valid_sig  = valid_q;
    assign err_sig    = err_q;
    assign period_sig = period_q;
    assign high_sig   = high_q;

endmodule

// File: tb/tb_div_meter.sv
// -----------------------------------------------------------------------------
// tb_div_meter
// Drives div_meter with a divider-like periodic pattern (period g_num, high
// g_duty). Each measurement request pushes the expected outcome onto a queue;
// a negedge monitor pops and compares whenever valid_sig or err_sig fires.
// -----------------------------------------------------------------------------
module tb_div_meter;

    localparam int WIDTH = 8;
`ifdef DIV_METER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 1;
`endif

    logic             clk_sig = 1'b0;
    logic             rst_sig;
    logic             in_sig;
    logic             start_sig;
    logic             busy_sig;
    logic             valid_sig;
    logic             err_sig;
    logic [WIDTH-1:0] period_sig;
    logic [WIDTH-1:0] high_sig;

    div_meter #(.WIDTH(WIDTH)) dut (
        .clk_sig    (clk_sig),
        .rst_sig    (rst_sig),
        .in_sig     (in_sig),
        .start_sig  (start_sig),
        .busy_sig   (busy_sig),
        .valid_sig  (valid_sig),
        .err_sig    (err_sig),
        .period_sig (period_sig),
        .high_sig   (high_sig)
    );

    always #5 clk_sig = ~clk_sig;

    typedef struct packed {
        logic             is_err;
        logic [WIDTH-1:0] period;
        logic [WIDTH-1:0] high;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_events = 0;
    int   ref_period = 0;
    int   ref_high   = 0;
    int   held_period = 0;
    int   held_high   = 0;
    logic prev_pulse  = 1'b0;

    // pattern generator state
    int   g_num   = 4;
    int   g_duty  = 2;
    int   g_phase = 0;
    logic gen_en  = 1'b0;

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Divider model: high for g_duty cycles, low for g_num-g_duty cycles.
    initial begin
        in_sig = 1'b0;
        forever begin
            @(posedge clk_sig);
            #2;
            if (gen_en) begin
                in_sig  = (g_phase < g_duty);
                g_phase = (g_phase + 1 >= g_num) ? 0 : g_phase + 1;
            end else begin
                in_sig = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_sig);
            if (rst_sig) begin
                held_period = 0;
                held_high   = 0;
                prev_pulse  = 1'b0;
            end else begin
                if (valid_sig || err_sig) begin
                    check("valid_err_exclusive", int'(valid_sig & err_sig), 0);
                    check("pulse_one_cycle", int'(prev_pulse), 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind_err", int'(err_sig), int'(e.is_err));
                        check("period", int'(period_sig), int'(e.period));
                        check("high", int'(high_sig), int'(e.high));
                    end
                    n_events++;
                end
                if (valid_sig) begin
                    held_period = int'(period_sig);
                    held_high   = int'(high_sig);
                end else if (err_sig) begin
                    check("hold_period_on_err", int'(period_sig), held_period);
                    check("hold_high_on_err", int'(high_sig), held_high);
                end
                prev_pulse = valid_sig | err_sig;
            end
        end
    end

    task automatic push_meas(input int num, input int duty);
        exp_t e;
        e.is_err = 1'b0;
        e.period = WIDTH'(num);
        e.high   = WIDTH'(duty);
        exp_q.push_back(e);
        ref_period = num;
        ref_high   = duty;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.period = WIDTH'(ref_period);
        e.high   = WIDTH'(ref_high);
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge clk_sig); #1 start_sig = 1'b1;
        @(posedge clk_sig); #1 start_sig = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk_sig);
        #1;
    endtask

    task automatic wait_events(input int target, input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if (n_events >= target) break;
            @(posedge clk_sig);
        end
        #1;
        check(name, n_events, target);
    endtask

    task automatic set_pattern(input int num, input int duty, input int ph);
        g_num   = num;
        g_duty  = duty;
        g_phase = ph;
        gen_en  = 1'b1;
        wait_cycles(2 * num + 4);
    endtask

    task automatic measure(input int num, input int duty, input string name);
        int target;
        set_pattern(num, duty, 0);
        push_meas(num, duty);
        target = n_events + 1;
        pulse_start();
        wait_events(target, 4 * num + 40, name);
    endtask

    initial begin
        int cnt;
        int saved;
        int num;
        int duty;
        rst_sig   = 1'b1;
        start_sig = 1'b0;
        wait_cycles(3);
        check("rst_busy", int'(busy_sig), 0);
        check("rst_valid", int'(valid_sig), 0);
        check("rst_err", int'(err_sig), 0);
        check("rst_period", int'(period_sig), 0);
        check("rst_high", int'(high_sig), 0);
        rst_sig = 1'b0;
        wait_cycles(4);

        // NUM=4 DUTY=2, pattern starts together with start_sig to fix latency.
        @(posedge clk_sig); #1;
        start_sig = 1'b1;
        g_num = 4; g_duty = 2; g_phase = 0; gen_en = 1'b1;
        push_meas(4, 2);
        @(posedge clk_sig); #1 start_sig = 1'b0;
        cnt = 1;
        check("busy_after_start", int'(busy_sig), 1);
        while (!valid_sig && cnt < 60) begin
            @(posedge clk_sig); #1 cnt++;
        end
        check("latency_n4", cnt, 4 + SYNC_LAT + 1);
        wait_events(1, 20, "events_n4");

        measure(5, 1, "events_n5d1");
        measure(5, 4, "events_n5d4");

        // Timeout: in_sig held low.
        gen_en = 1'b0;
        wait_cycles(4);
        push_err();
        saved = n_events;
        pulse_start();
        check("busy_wait_rise", int'(busy_sig), 1);
        cnt = 0;
        while (!err_sig && cnt < 400) begin
            @(posedge clk_sig); #1 cnt++;
        end
        check("timeout_cycles", cnt, 255);
        wait_events(saved + 1, 10, "events_timeout");
        wait_cycles(2);
        check("idle_after_err", int'(busy_sig), 0);

        // Start re-pulsed while busy, then start in the valid cycle.
        set_pattern(7, 3, 0);
        push_meas(7, 3);
        saved = n_events;
        pulse_start();
        wait_cycles(2);
        check("busy_before_repulse", int'(busy_sig), 1);
        pulse_start();
        cnt = 0;
        while (!valid_sig && cnt < 60) begin
            @(posedge clk_sig); #1 cnt++;
        end
        start_sig = 1'b1;
        push_meas(7, 3);
        @(posedge clk_sig); #1 start_sig = 1'b0;
        check("busy_second_meas", int'(busy_sig), 1);
        wait_events(saved + 2, 80, "events_back_to_back");

        // Longest measurable period for WIDTH=8.
        measure(254, 100, "events_n254");

        // Randomized patterns.
        for (int k = 0; k < 10; k++) begin
            num  = $urandom_range(40, 2);
            duty = $urandom_range(num - 1, 1);
            set_pattern(num, duty, $urandom_range(num - 1, 0));
            wait_cycles($urandom_range(7, 0));
            push_meas(num, duty);
            saved = n_events;
            pulse_start();
            wait_events(saved + 1, 4 * num + 40, "events_random");
        end

        // Asynchronous reset in the middle of a measurement.
        gen_en = 1'b0;
        wait_cycles(4);
        @(posedge clk_sig); #1;
        start_sig = 1'b1;
        g_num = 30; g_duty = 12; g_phase = 0; gen_en = 1'b1;
        @(posedge clk_sig); #1 start_sig = 1'b0;
        wait_cycles(15);
        check("busy_mid_measure", int'(busy_sig), 1);
        #2 rst_sig = 1'b1;
        #1;
        check("async_rst_busy", int'(busy_sig), 0);
        check("async_rst_valid", int'(valid_sig), 0);
        check("async_rst_err", int'(err_sig), 0);
        check("async_rst_period", int'(period_sig), 0);
        check("async_rst_high", int'(high_sig), 0);
        exp_q.delete();
        ref_period = 0;
        ref_high   = 0;
        wait_cycles(2);
        rst_sig = 1'b0;
        saved = n_events;
        wait_cycles(80);
        check("no_event_after_reset", n_events, saved);
        push_meas(30, 12);
        pulse_start();
        wait_events(saved + 1, 160, "events_after_reset");

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
